// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and flush.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 96,
    parameter int unsigned CTRL_W = 5,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [RD_W-1:0]   out_rd,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [RD_W-1:0]   main_rd_q, main_rd_d, skid_rd_q, skid_rd_d;

    logic acc, drn;

    // in_ready is a function of registered state only, so no out_ready -> in_ready path.
    assign in_ready  = (state_q != StTwo);
    assign out_valid = (state_q != StEmpty);
    assign acc       = in_valid & in_ready;
    assign drn       = out_valid & out_ready;

    assign out_data = main_data_q;
    assign out_ctrl = main_ctrl_q & {CTRL_W{out_valid}};
    assign out_rd   = main_rd_q;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        main_rd_d   = main_rd_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_rd_d   = skid_rd_q;

        case (state_q)
            StEmpty: begin
                if (acc) begin
                    state_d     = StOne;
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                    main_rd_d   = in_rd;
                end
            end
            StOne: begin
                if (acc && drn) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                    main_rd_d   = in_rd;
                end else if (acc) begin
                    state_d     = StTwo;
                    skid_data_d = in_data;
                    skid_ctrl_d = in_ctrl;
                    skid_rd_d   = in_rd;
                end else if (drn) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (drn) begin
                    state_d     = StOne;
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                    main_rd_d   = skid_rd_q;
                end
            end
            default: state_d = StEmpty;
        endcase

        // Flush drops everything, including an entry accepted this cycle.
        if (flush) begin
            state_d     = StEmpty;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StEmpty;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            main_rd_q   <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_rd_q   <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            main_rd_q   <= main_rd_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_rd_q   <= skid_rd_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q;

    // Saturating counters, cleared by rst only; flush cycles count on pre-flush state.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (!out_valid && (bubble_cnt_q != '1)) begin
                bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register for the pipelined CPU; successor to the fixed-field EX/MEM register.
- Carries a generic data bundle, control bundle and destination-register index between stages.
- Adds a valid/ready handshake, a 2-entry skid buffer (full throughput under back-pressure), flush, and bubble-safe control masking.
- Instantiated between any two stages (ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 96, width of data bundle (e.g. inst + RFRD2 + ALUOUT)
- CTRL_W, 5, width of control bundle (RegDst, MemRead, MemtoReg, MemWrite, RegWrite)
- RD_W, 5, destination register index width
- CNT_W, 16, performance counter width (used only with optional feature)

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all held entries this cycle
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry
- in_data  in  DATA_W  upstream data bundle
- in_ctrl  in  CTRL_W  upstream control bundle
- in_rd  in  RD_W  upstream destination register
- out_valid  out  1  entry present at output
- out_ready  in  1  downstream accepts entry
- out_data  out  DATA_W  held data
- out_ctrl  out  CTRL_W  held control, forced 0 when out_valid=0
- out_rd  out  RD_W  held destination register
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0
- bubble_cnt  out  CNT_W  cycles with out_valid=0

Behaviour:
- Storage: main entry (drives outputs) and skid entry, each holding data/ctrl/rd.
- Encoded state: EMPTY, ONE (main full), TWO (main and skid full).
- acc = in_valid & in_ready; drn = out_valid & out_ready.
- in_ready = (state != TWO). It depends only on registered state; there is no combinational path from out_ready.
- out_valid = (state != EMPTY).
- Transitions (no rst/flush):
  - EMPTY: acc -> ONE, main<=in; else EMPTY.
  - ONE: acc&drn -> ONE, main<=in; acc&!drn -> TWO, skid<=in; !acc&drn -> EMPTY; else ONE, main held.
  - TWO: drn -> ONE, main<=skid; else TWO, all held.
- Latency: in to out is 1 cycle. Sustained throughput is 1 entry/cycle with out_ready=1.
- Ordering: strict FIFO; the skid entry always leaves after main.
- Reset (rst=1, highest priority):
  - state=EMPTY; main and skid data/ctrl/rd = 0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, out_ctrl=0, out_rd=0, counters=0.
- Flush (rst=0, flush=1):
  - state=EMPTY; main/skid ctrl cleared to 0; data/rd may hold.
  - Any same-cycle acc is consumed and discarded.
  - Next cycle: in_ready=1, out_valid=0.
- Bubble masking: out_ctrl = main_ctrl AND out_valid, so a bubble never asserts RegWrite or MemWrite.
- Upstream inputs are ignored when in_ready=0. in_valid may drop without acceptance.
- Reset or flush mid-transfer (state TWO) loses both entries; no partial output is visible.

Optional Feature:
Macro PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt increments each cycle out_valid=1 & out_ready=0.
  - bubble_cnt increments each cycle out_valid=0.
  - Both saturate at all-ones.
  - Both are cleared by rst only, not by flush. Flush cycles count per the pre-flush out_valid.
- Undefined: counter logic is absent and stall_cnt and bubble_cnt are tied to 0. Ports remain.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1, in_ctrl=5'h1F -> out_valid=0, out_ctrl=0, in_ready=1, counters=0. First accept after release appears next cycle.
- Streaming: out_ready=1, in_valid=1 for 8 cycles with in_data=1..8 -> out_data=1..8 on consecutive cycles, each 1 cycle late; in_ready constantly 1.
- Back-pressure:
  - Send data A, B, C with out_ready=0 -> A in main, B in skid, in_ready=0 from the cycle after B; C held upstream.
  - Raise out_ready -> outputs A, B, C in order with no loss or duplication.
  - With PIPE_STAGE_PERF_EN, stall_cnt equals the out_ready=0 cycles with out_valid=1.
- Flush in TWO with in_ctrl=5'h1F -> next cycle out_valid=0, out_ctrl=0, in_ready=1. The flushed entries never appear.
- Simultaneous flush and acc of D -> D discarded; the following accepted E appears next.
- Saturation: with PIPE_STAGE_PERF_EN and CNT_W=4, idle 20 cycles -> bubble_cnt=4'hF and holds. Without the macro, both counters read 0.
